inert_integrator_p: RTL
=======================

# inert_integrator_p

Parametrised heading integrator for the inertial interface. It calibrates the gyro yaw-rate offset by averaging a configurable number of samples, then integrates offset-corrected yaw rate into a wrapping heading. It applies guardrail IR fusion and gates integration with `moving`. It sits between the SPI/iNEMO sample-capture logic, which supplies `vld`/`yaw_rt`, and the navigation consumers of `heading`/`rdy`.

## Interface
- `FAST_SIM`, 1: selects `FAST_CAL_LOG2` instead of `CAL_LOG2`
- `CAL_LOG2`, 11: log2 of calibration sample count
- `FAST_CAL_LOG2`, 8: log2 of calibration sample count when `FAST_SIM`=1
- `RATE_W`, 16: yaw-rate sample width (signed)
- `HEAD_W`, 12: heading width
- `FRAC_W`, 8: fractional accumulator bits; accumulator width `ACC_W` = `HEAD_W`+`FRAC_W`
- `FUSION_GAIN`, 32: per-sample accumulator correction when exactly one IR flag is set
- `DEADBAND`, 4: magnitude threshold used only with `INERT_DEADBAND_EN`
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `strt_cal`  in  1  one-cycle pulse; starts or restarts calibration
- `vld`  in  1  new `yaw_rt` sample this cycle
- `yaw_rt`  in  `RATE_W`  signed raw yaw rate
- `moving`  in  1  integrate only when high
- `lftIR`, `rghtIR`  in  1 each  guardrail flags
- `cal_done`  out  1  one-cycle pulse when calibration completes
- `rdy`  out  1  one-cycle pulse when `heading` has been updated
- `heading`  out  `HEAD_W`  signed heading, wraps modulo 2^`HEAD_W`

## Operation
- Reset state of every output and register: state=IDLE, `cal_done`=0, `rdy`=0, `heading`=0, accumulator=0, offset=0, sample count=0.
- **IDLE**
  - `vld` is ignored.
  - `strt_cal` moves to CAL. It clears the cal sum, sample count, accumulator and `heading`.
- **CAL**
  - Each `vld` adds the sign-extended `yaw_rt` to the sum. The sum is `RATE_W`+`CAL_LOG2` bits.
  - The count increments on each `vld`.
  - On the Nth `vld` (N = 2^log2):
    - offset becomes the sum shifted arithmetically right by log2 (truncation toward −inf).
    - `cal_done` pulses.
    - state moves to RUN.
  - `rdy` is never asserted in CAL.
- **RUN**, per accepted `vld`, as a two-stage pipeline:
  - Stage 1 registers `comp` = `yaw_rt` − offset, saturated to `RATE_W` bits. It also registers the `moving`, `lftIR` and `rghtIR` values sampled with `vld`.
  - Stage 2 builds the update term. When moving=1, the term is sign-extended `comp`, plus `FUSION_GAIN` if lftIR & !rghtIR, or minus `FUSION_GAIN` if rghtIR & !lftIR. Both or neither IR flags set gives no fusion. When moving=0, the term is 0.
  - Stage 2 then does accumulator += term, modulo 2^`ACC_W` (wraps, no saturation).
  - `heading` = accumulator[`ACC_W`-1:`FRAC_W`].
  - `rdy` pulses whenever stage 2 fires, including when moving=0 (heading unchanged in that case).
- **Boundary conditions**
  - `strt_cal` in any state, including mid-CAL or with samples in the pipeline:
    - restarts CAL and flushes both pipeline stages;
    - produces no `rdy` for flushed samples;
    - a `vld` in the same cycle as `strt_cal` is discarded.
  - Back-to-back `vld` every cycle is supported in CAL and RUN, with no drops.
  - `comp` saturation:
    - if `yaw_rt`=−2^(`RATE_W`-1) and offset>0, `comp` clamps to −2^(`RATE_W`-1);
    - if `yaw_rt`=2^(`RATE_W`-1)−1 and offset<0, `comp` clamps to 2^(`RATE_W`-1)−1.
  - Reset asserted mid-operation returns everything to the reset state immediately (asynchronous).

## Timing
- CAL completion: if the Nth `vld` is sampled at edge k, offset is updated, `cal_done`=1 and state=RUN at edge k+1, and `cal_done` returns to 0 at edge k+2.
- The first RUN sample can arrive in the cycle after `cal_done` is high.
- RUN latency: a `vld` sampled at edge k updates stage 1 at k+1, then `heading` and `rdy`=1 at k+2. `rdy` is high for exactly one cycle per sample.
- `heading` holds its value between updates.

## Configuration
- `INERT_DEADBAND_EN` defined: in stage 2, if |`comp`| < `DEADBAND`, `comp` is treated as 0. Fusion still applies.
- `INERT_DEADBAND_EN` undefined: no deadband logic is present, and the `DEADBAND` parameter is unused.

## Structure
- Package `inert_pkg` holds:
  - the state enum (IDLE, CAL, RUN);
  - the default width/gain localparams;
  - the function computing calibration log2 from `FAST_SIM`.
- Sub-module `inert_cal_avg` holds the calibration sum, counter and offset register, and generates the done pulse. The top holds the FSM, the pipeline and the accumulator.

## Test plan
- Defaults, `FAST_SIM`=1, `strt_cal` then 256 `vld` with `yaw_rt`=100: `cal_done` pulses once, 1 cycle after the 256th `vld`; offset=100; `heading`=0; no `rdy` during CAL.
- After that cal, moving=1 and 16 back-to-back `vld` with `yaw_rt`=356 (`comp`=256): 16 `rdy` pulses, the first 2 cycles after the first `vld`; `heading` steps 1..16.
- 4096 samples with `comp`=256: `heading` wraps from 2047 to −2048 and ends at 0.
- moving=0 with `yaw_rt`=356 for 10 samples: 10 `rdy` pulses, `heading` unchanged. `yaw_rt`=100 with lftIR=1, 8 samples: `heading` +1. rghtIR=1, 8 samples: `heading` −1. Both flags set: no change.
- Offset=100 and `yaw_rt`=−32768: `comp` saturates to −32768, and the accumulator drops by 32768 (`heading` −128).
- `strt_cal` with a sample in flight: no `rdy` for it; `heading`=0; recalibration completes after 256 fresh samples. `rst_n` low mid-CAL: all outputs return to 0 asynchronously.

Source files
------------

// File: rtl/inert_pkg.sv
// Shared types and defaults for the inertial heading integrator.
// Build option: INERT_DEADBAND_EN enables the stage-2 deadband on corrected yaw rate.
package inert_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAL  = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam int DEF_CAL_LOG2      = 11;
    localparam int DEF_FAST_CAL_LOG2 = 8;
    localparam int DEF_RATE_W        = 16;
    localparam int DEF_HEAD_W        = 12;
    localparam int DEF_FRAC_W        = 8;
    localparam int DEF_FUSION_GAIN   = 32;
    localparam int DEF_DEADBAND      = 4;

    function automatic int cal_log2_f(input int fast_sim, input int cal_log2, input int fast_log2);
        if (fast_sim != 0) begin
            return fast_log2;
        end else begin
            return cal_log2;
        end
    endfunction

endpackage

// File: rtl/inert_cal_avg.sv
// Gyro offset calibration: sums 2^LOG2 samples, latches the floored mean and pulses done.
module inert_cal_avg
    import inert_pkg::*;
#(
    parameter int RATE_W = DEF_RATE_W,
    parameter int LOG2   = DEF_FAST_CAL_LOG2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     smp_en,
    input  logic signed [RATE_W-1:0] yaw_rt,
    output logic                     last,
    output logic                     done,
    output logic signed [RATE_W-1:0] offset
);

    localparam int SUM_W = RATE_W + LOG2;

    logic [SUM_W-1:0]         sum_q, sum_d, sum_nxt_s;
    logic [LOG2-1:0]          cnt_q, cnt_d;
    logic signed [RATE_W-1:0] off_q, off_d;
    logic                     done_q, done_d;
    logic                     last_s;

    // Next-state for sum, count and offset; the top bits of the final sum are the floored mean
    always_comb begin
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        off_d     = off_q;
        done_d    = 1'b0;
        sum_nxt_s = sum_q + {{LOG2{yaw_rt[RATE_W-1]}}, yaw_rt};
        last_s    = smp_en && (cnt_q == {LOG2{1'b1}});
        if (clr) begin
            sum_d = {SUM_W{1'b0}};
            cnt_d = {LOG2{1'b0}};
        end else if (smp_en) begin
            cnt_d = cnt_q + {{(LOG2-1){1'b0}}, 1'b1};
            if (last_s) begin
                sum_d  = {SUM_W{1'b0}};
                off_d  = sum_nxt_s[SUM_W-1:LOG2];
                done_d = 1'b1;
            end else begin
                sum_d = sum_nxt_s;
            end
        end else begin
            sum_d = sum_q;
        end
    end

    // Calibration state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= {SUM_W{1'b0}};
            cnt_q  <= {LOG2{1'b0}};
            off_q  <= {RATE_W{1'b0}};
            done_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cnt_q  <= cnt_d;
            off_q  <= off_d;
            done_q <= done_d;
        end
    end

    assign last   = last_s;
    assign done   = done_q;
    assign offset = off_q;

endmodule

// File: rtl/inert_integrator_p.sv
// Heading integrator: FSM, two-stage offset-correct/accumulate pipeline with IR fusion.
// Build option: INERT_DEADBAND_EN zeroes small corrected rates before accumulation.
module inert_integrator_p
    import inert_pkg::*;
#(
    parameter int FAST_SIM      = 1,
    parameter int CAL_LOG2      = DEF_CAL_LOG2,
    parameter int FAST_CAL_LOG2 = DEF_FAST_CAL_LOG2,
    parameter int RATE_W        = DEF_RATE_W,
    parameter int HEAD_W        = DEF_HEAD_W,
    parameter int FRAC_W        = DEF_FRAC_W,
    parameter int FUSION_GAIN   = DEF_FUSION_GAIN,
    parameter int DEADBAND      = DEF_DEADBAND
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     strt_cal,
    input  logic                     vld,
    input  logic signed [RATE_W-1:0] yaw_rt,
    input  logic                     moving,
    input  logic                     lftIR,
    input  logic                     rghtIR,
    output logic                     cal_done,
    output logic                     rdy,
    output logic signed [HEAD_W-1:0] heading
);

    localparam int LOG2  = cal_log2_f(FAST_SIM, CAL_LOG2, FAST_CAL_LOG2);
    localparam int ACC_W = HEAD_W + FRAC_W;
    localparam logic signed [RATE_W-1:0] RATE_MAX = {1'b0, {(RATE_W-1){1'b1}}};
    localparam logic signed [RATE_W-1:0] RATE_MIN = {1'b1, {(RATE_W-1){1'b0}}};

    state_e                   state_q, state_d;
    logic                     s1_vld_q, s1_vld_d;
    logic signed [RATE_W-1:0] comp_q, comp_d;
    logic                     mov_q, mov_d, lft_q, lft_d, rght_q, rght_d;
    logic [ACC_W-1:0]         acc_q, acc_d;
    logic signed [HEAD_W-1:0] heading_q, heading_d;
    logic                     rdy_q, rdy_d;

    logic signed [RATE_W-1:0] offset_s, sat_s, comp_eff_s;
    logic signed [RATE_W:0]   diff_s;
    logic [ACC_W-1:0]         term_s, acc_nxt_s;
    logic                     cal_en_s, run_en_s, cal_last_s, cal_done_s;

    assign cal_en_s = (state_q == CAL) && vld && !strt_cal;
    assign run_en_s = (state_q == RUN) && vld && !strt_cal;

    inert_cal_avg #(
        .RATE_W (RATE_W),
        .LOG2   (LOG2)
    ) u_cal (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (strt_cal),
        .smp_en (cal_en_s),
        .yaw_rt (yaw_rt),
        .last   (cal_last_s),
        .done   (cal_done_s),
        .offset (offset_s)
    );

    // Stage 1: offset subtraction with one guard bit, clamped back to RATE_W
    always_comb begin
        diff_s = {yaw_rt[RATE_W-1], yaw_rt} - {offset_s[RATE_W-1], offset_s};
        if (diff_s[RATE_W] != diff_s[RATE_W-1]) begin
            if (diff_s[RATE_W]) begin
                sat_s = RATE_MIN;
            end else begin
                sat_s = RATE_MAX;
            end
        end else begin
            sat_s = diff_s[RATE_W-1:0];
        end
    end

    // Stage 2: update term with guardrail fusion; the accumulator wraps freely
    always_comb begin
        comp_eff_s = comp_q;
`ifdef INERT_DEADBAND_EN
        if ((comp_q > -RATE_W'(DEADBAND)) && (comp_q < RATE_W'(DEADBAND))) begin
            comp_eff_s = {RATE_W{1'b0}};
        end else begin
            comp_eff_s = comp_q;
        end
`endif
        term_s = {ACC_W{1'b0}};
        if (mov_q) begin
            term_s = {{(ACC_W-RATE_W){comp_eff_s[RATE_W-1]}}, comp_eff_s};
            if (lft_q && !rght_q) begin
                term_s = term_s + ACC_W'(FUSION_GAIN);
            end else if (rght_q && !lft_q) begin
                term_s = term_s - ACC_W'(FUSION_GAIN);
            end else begin
                term_s = term_s;
            end
        end else begin
            term_s = {ACC_W{1'b0}};
        end
        acc_nxt_s = acc_q + term_s;
    end

    // FSM next state and pipeline control; strt_cal flushes everything in flight
    always_comb begin
        state_d   = state_q;
        s1_vld_d  = 1'b0;
        comp_d    = comp_q;
        mov_d     = mov_q;
        lft_d     = lft_q;
        rght_d    = rght_q;
        acc_d     = acc_q;
        heading_d = heading_q;
        rdy_d     = 1'b0;
        case (state_q)
            IDLE:    state_d = strt_cal ? CAL : IDLE;
            CAL: begin
                if (strt_cal) begin
                    state_d = CAL;
                end else if (cal_last_s) begin
                    state_d = RUN;
                end else begin
                    state_d = CAL;
                end
            end
            RUN:     state_d = strt_cal ? CAL : RUN;
            default: state_d = IDLE;
        endcase
        if (strt_cal) begin
            acc_d     = {ACC_W{1'b0}};
            heading_d = {HEAD_W{1'b0}};
        end else begin
            s1_vld_d = run_en_s;
            if (run_en_s) begin
                comp_d = sat_s;
                mov_d  = moving;
                lft_d  = lftIR;
                rght_d = rghtIR;
            end else begin
                comp_d = comp_q;
            end
            if (s1_vld_q) begin
                acc_d     = acc_nxt_s;
                heading_d = acc_nxt_s[ACC_W-1:FRAC_W];
                rdy_d     = 1'b1;
            end else begin
                acc_d = acc_q;
            end
        end
    end

    // FSM, pipeline and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            s1_vld_q  <= 1'b0;
            comp_q    <= {RATE_W{1'b0}};
            mov_q     <= 1'b0;
            lft_q     <= 1'b0;
            rght_q    <= 1'b0;
            acc_q     <= {ACC_W{1'b0}};
            heading_q <= {HEAD_W{1'b0}};
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            s1_vld_q  <= s1_vld_d;
            comp_q    <= comp_d;
            mov_q     <= mov_d;
            lft_q     <= lft_d;
            rght_q    <= rght_d;
            acc_q     <= acc_d;
            heading_q <= heading_d;
            rdy_q     <= rdy_d;
        end
    end

    assign cal_done = cal_done_s;
    assign rdy      = rdy_q;
    assign heading  = heading_q;

endmodule
